timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter: WIDTH, default 5, width of count and limit.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: resetn  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin a count run; sampled only in IDLE.
REQ-005 Port: stop  input  1  abort request; sampled only in RUN.
REQ-006 Port: limit  input  WIDTH  terminal count; captured into limit_q on accepted start.
REQ-007 Port: ack  input  1  completion acknowledge; sampled only in DONE.
REQ-008 Port: count  output  WIDTH  current counter value, registered.
REQ-009 Port: busy  output  1  high exactly while state is RUN, registered.
REQ-010 Port: done  output  1  completion flag, registered.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, DONE, with encoding internal to the block.
REQ-012 IDLE, start=1: next edge → RUN, limit_q=limit, count=0, busy=1.
REQ-013 IDLE, start=0: state, count and limit_q hold; stop and ack are ignored.
REQ-014 RUN, stop=0, count!=limit_q: count increments by 1 per edge, unsigned, WIDTH bits.
REQ-015 RUN, stop=0, count==limit_q: next edge → DONE, done=1, busy=0, count holds limit_q.
REQ-016 RUN, stop=1: next edge → IDLE, busy=0, done stays 0, count holds its current value; stop wins over a simultaneous terminal match.
REQ-017 RUN: start and ack are ignored, and limit changes do not affect limit_q.
REQ-018 DONE: done=1 and count holds until ack=1; the next edge after ack → IDLE, done=0.
REQ-019 DONE: start is ignored, so a new run needs IDLE first; start is accepted at the earliest on the edge after return to IDLE.
REQ-020 Latency: start accepted at edge E0 → done=1 after edge E0+limit_q+1; limit=0 → done after E0+1.
REQ-021 count SHALL never exceed limit_q, so no wrap-around occurs in the default configuration; limit=2^WIDTH-1 SHALL complete normally.
REQ-022 The counter SHALL be a ripple-carry incrementer with per-bit XOR/carry, no arithmetic operator on count, held via per-bit enable.

Reset
REQ-023 resetn=0 SHALL immediately, without a clock, force state=IDLE, count=0, limit_q=0, busy=0, done=0.
REQ-024 Reset asserted mid-RUN or mid-DONE SHALL abandon the run with no done pulse; after release the block waits in IDLE for start.
REQ-025 The first edge after resetn rises SHALL honour start normally.

Configuration
REQ-026 Macro TIMER_CTRL_AUTORELOAD_EN SHALL select autoreload mode when defined.
REQ-027 Without the macro, REQ-015 and REQ-018 apply as written.
REQ-028 With the macro, RUN at count==limit_q and stop=0 SHALL stay in RUN with count=0 next edge and done=1 for exactly that one cycle.
REQ-029 With the macro, DONE is never entered, ack is ignored, and stop remains the only exit from RUN.

Verification
REQ-030 Reset mid-run: start with limit=10, assert resetn=0 when count=6 → outputs immediately 0, state IDLE, no done.
REQ-031 Normal run: limit=5, start 1 cycle → count 0,1,2,3,4,5 on successive edges, busy=1 for 6 cycles; done=1 and count=5 held; ack → IDLE next edge, done=0.
REQ-032 Edge limits: limit=0 → done after 1 edge with count=0; limit=31 → done after 32 edges with count=31 and no wrap.
REQ-033 Abort: limit=20, stop at count=7 → IDLE, count=7, done=0; stop coincident with count==limit_q → IDLE, no done.
REQ-034 Ignored inputs: start held through RUN/DONE and limit changed during RUN → limit_q unchanged, no restart until IDLE.
REQ-035 TIMER_CTRL_AUTORELOAD_EN defined: limit=3 → count 0,1,2,3,0,1… with a one-cycle done pulse each time count=3; stop → IDLE.

Source files
------------

// File: rtl/timer_ctrl.sv
// timer_ctrl: three-state count timer (IDLE -> RUN -> DONE -> IDLE).
// A run begins on start in IDLE and captures limit. The counter then steps
// from 0 up to the captured limit. After that the block waits in DONE until
// ack is seen. stop aborts a run and keeps the current count.
// Optional build macro TIMER_CTRL_AUTORELOAD_EN: at the terminal count the
// counter reloads to 0 and stays in RUN, and done pulses for one cycle.
// In that mode DONE is never entered.
module timer_ctrl #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] limit,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] limit_q;
    logic             busy_q;
    logic             done_q;

    logic             match;
    logic             cnt_clr;
    logic             cnt_inc;
    logic [WIDTH-1:0] bit_en;

    assign match = (count_q == limit_q);

    // Counter control: clear on accepted start (and on reload), step while running below limit
    always_comb begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (state_q == IDLE && start) begin
            cnt_clr = 1'b1;
        end else if (state_q == RUN && !stop) begin
            if (!match) begin
                cnt_inc = 1'b1;
            end
`ifdef TIMER_CTRL_AUTORELOAD_EN
            else begin
                cnt_clr = 1'b1;
            end
`endif
        end
    end

    // Ripple-carry incrementer: a bit toggles only when the carry into it is set
    always_comb begin
        logic c;
        c       = cnt_inc;
        bit_en  = '0;
        count_d = count_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bit_en[i]  = c;
            count_d[i] = cnt_clr ? 1'b0 : (count_q[i] ^ bit_en[i]);
            c          = c & count_q[i];
        end
    end

    // Control FSM with registered count, limit, busy and done
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        limit_q <= limit;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (match) begin
`ifdef TIMER_CTRL_AUTORELOAD_EN
                        done_q  <= 1'b1;
`else
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        done_q  <= 1'b0;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl. The reference model tracks each run as
// "edges elapsed since the accepting start". Every stimulus cycle compares
// the DUT outputs with this model. Hand-computed literal checks pin the
// model at key points. Define TIMER_CTRL_AUTORELOAD_EN to cover reload mode.
module tb_timer_ctrl;

    localparam int unsigned WIDTH = 5;
`ifdef TIMER_CTRL_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic             clk;
    logic             resetn;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] limit;
    logic             ack;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    int compared;
    int mismatched;

    timer_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .resetn(resetn),
        .start (start),
        .stop  (stop),
        .limit (limit),
        .ack   (ack),
        .count (count),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int n;          // edges since reset release
    bit run_on;     // a run is in progress
    bit done_wait;  // run finished, awaiting ack
    int t0;         // edge index at which the run was accepted
    int lim;        // captured limit
    int hold;       // count shown outside a run
    int exp_count;
    bit exp_busy;
    bit exp_done;

    function automatic int cnt_at(input int k);
        if (AR) return k % (lim + 1);
        return k;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                n = 0; run_on = 1'b0; done_wait = 1'b0; t0 = 0; lim = 0; hold = 0;
            end else begin
                n = n + 1;
                if (done_wait) begin
                    if (ack) done_wait = 1'b0;
                end else if (run_on) begin
                    if (stop) begin
                        run_on = 1'b0;
                        hold   = cnt_at(n - 1 - t0);
                    end else if (!AR && (n - t0) == lim + 1) begin
                        run_on    = 1'b0;
                        done_wait = 1'b1;
                        hold      = lim;
                    end
                end else if (start) begin
                    run_on = 1'b1;
                    t0     = n;
                    lim    = int'(limit);
                end
            end
            exp_busy  = run_on;
            exp_count = run_on ? cnt_at(n - t0) : hold;
            exp_done  = done_wait ||
                        (AR && run_on && (n > t0) && ((n - t0) % (lim + 1) == 0));
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_chk();
        chk("model_count", int'(count), exp_count);
        chk("model_busy",  int'(busy),  int'(exp_busy));
        chk("model_done",  int'(done),  int'(exp_done));
    endtask

    // one clock edge, then compare all outputs against the model
    task automatic step();
        @(posedge clk);
        #1;
        model_chk();
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic lit(input string nm, input int c, input int b, input int d);
        chk({nm, "_count"}, int'(count), c);
        chk({nm, "_busy"},  int'(busy),  b);
        chk({nm, "_done"},  int'(done),  d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        compared   = 0;
        mismatched = 0;
        resetn = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0; limit = '0;
        #3;
        lit("reset", 0, 0, 0);
        steps(2);
        resetn = 1'b1;
        step();
        lit("idle_after_reset", 0, 0, 0);

        // stop/ack in IDLE are ignored
        stop = 1'b1; ack = 1'b1; limit = 5'd9;
        steps(2);
        lit("idle_ignore", 0, 0, 0);
        stop = 1'b0; ack = 1'b0;

        // reset mid-run at count 6, start held so the first edge after release starts
        limit = 5'd10; start = 1'b1;
        step();
        lit("rst_run_start", 0, 1, 0);
        steps(6);
        lit("rst_run_c6", 6, 1, 0);
        #1 resetn = 1'b0;
        #1;
        lit("rst_midrun", 0, 0, 0);
        model_chk();
        step();
        lit("rst_held", 0, 0, 0);
        resetn = 1'b1;
        limit = 5'd4;
        step();
        lit("rst_first_edge", 0, 1, 0);
        start = 1'b0;
        steps(2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        lit("rst_then_stop", 2, 0, 0);

`ifndef TIMER_CTRL_AUTORELOAD_EN
        // normal run, limit 5
        limit = 5'd5; start = 1'b1;
        step();
        start = 1'b0;
        lit("run5_e0", 0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("run5_seq", int'(count), k);
        end
        step();
        lit("run5_done", 5, 0, 1);
        steps(3);
        lit("run5_hold", 5, 0, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        lit("run5_ack", 5, 0, 0);

        // limit 0
        limit = 5'd0; start = 1'b1;
        step();
        start = 1'b0;
        lit("lim0_e0", 0, 1, 0);
        step();
        lit("lim0_done", 0, 0, 1);
        ack = 1'b1; step(); ack = 1'b0;

        // limit 31, no wrap
        limit = 5'd31; start = 1'b1;
        step();
        start = 1'b0;
        steps(31);
        lit("lim31_top", 31, 1, 0);
        step();
        lit("lim31_done", 31, 0, 1);
        ack = 1'b1; step(); ack = 1'b0;

        // abort at count 7
        limit = 5'd20; start = 1'b1;
        step();
        start = 1'b0;
        steps(7);
        stop = 1'b1;
        step();
        stop = 1'b0;
        lit("abort7", 7, 0, 0);
        steps(2);
        lit("abort7_hold", 7, 0, 0);

        // stop coincident with terminal count
        limit = 5'd3; start = 1'b1;
        step();
        start = 1'b0;
        steps(3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        lit("stop_at_match", 3, 0, 0);
        step();
        lit("stop_at_match_after", 3, 0, 0);

        // start held through RUN/DONE, limit changed during RUN, ack ignored in RUN
        limit = 5'd4; start = 1'b1;
        step();
        limit = 5'd2; ack = 1'b1;
        steps(4);
        lit("ign_run", 4, 1, 0);
        ack = 1'b0;
        step();
        lit("ign_done", 4, 0, 1);
        steps(2);
        lit("ign_done_hold", 4, 0, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        lit("ign_idle", 4, 0, 0);
        step();
        start = 1'b0;
        lit("ign_restart", 0, 1, 0);
        steps(2);
        step();
        lit("ign_restart_done", 2, 0, 1);

        // reset while in DONE
        #1 resetn = 1'b0;
        #1;
        lit("rst_done", 0, 0, 0);
        resetn = 1'b1;
        step();
        lit("rst_done_idle", 0, 0, 0);
`else
        // autoreload, limit 3: count 0,1,2,3,0,... with done on each reload
        limit = 5'd3; start = 1'b1;
        step();
        start = 1'b0;
        ack = 1'b1;
        lit("ar_e0", 0, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            step();
            lit("ar_seq", k % 4, 1, ((k % 4) == 0) ? 1 : 0);
        end
        ack = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        lit("ar_stop", 2, 0, 0);
        steps(2);
        lit("ar_idle", 2, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
